// File: rtl/regfile_mp.sv
// Multi-port register file with per-port writes, optional zero register,
// optional write-to-read bypass and a pending-write scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_adr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_adr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic                       rsv_en_i,
  input  logic [ADDR_W-1:0]          rsv_adr_i,
  output logic [ADDR_W:0]            pend_cnt_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wr_adr [NUM_WR];
  logic [DATA_W-1:0] wr_data [NUM_WR];

  logic [DATA_W-1:0] mem_reg  [DEPTH];
  logic [DATA_W-1:0] mem_next [DEPTH];
  logic [DEPTH-1:0]  pend_reg, pend_next;
  logic [ADDR_W:0]   pend_cnt_reg, pend_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign wr_adr[gi]  = wr_adr_i[gi*ADDR_W +: ADDR_W];
      assign wr_data[gi] = wr_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Ports are scanned in ascending order so the highest-index port wins,
  // and the reservation is applied last so a new producer supersedes a write.
  always_comb begin
    pend_next = pend_reg;
    for (int i = 0; i < DEPTH; i++) begin
      mem_next[i] = mem_reg[i];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && wr_adr[j] == ADDR_W'(i)) begin
          mem_next[i]  = wr_data[j];
          pend_next[i] = 1'b0;
        end
      end
      if (rsv_en_i && rsv_adr_i == ADDR_W'(i)) begin
        pend_next[i] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      mem_next[0]  = '0;
      pend_next[0] = 1'b0;
    end
  end

  always_comb begin
    pend_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_next = pend_cnt_next + {{ADDR_W{1'b0}}, pend_next[i]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      pend_reg     <= '0;
      pend_cnt_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= mem_next[i];
      end
      pend_reg     <= pend_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign pend_cnt_o = pend_cnt_reg;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign adr = rd_adr_i[gi*ADDR_W +: ADDR_W];

      // Reset is folded in so that bypassed write data cannot leak out
      // while the array is being cleared.
      always_comb begin
        data = mem_reg[adr];
        busy = pend_reg[adr];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && wr_adr[j] == adr) begin
              data = wr_data[j];
              busy = 1'b0;
            end
          end
        end
        if ((ZERO_REG != 0 && adr == '0) || rst_i) begin
          data = '0;
          busy = 1'b0;
        end
      end

      assign rd_data_o[gi*DATA_W +: DATA_W] = data;
      assign rd_busy_o[gi]                  = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance are
// checked every cycle against an array model, plus hand-computed literals.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [NR*AW-1:0] rd_adr_i = '0;
  logic [NR*DW-1:0] rd_data_o, rd_data_nb;
  logic [NR-1:0]    rd_busy_o, rd_busy_nb;
  logic [NW-1:0]    wr_en_i = '0;
  logic [NW*AW-1:0] wr_adr_i = '0;
  logic [NW*DW-1:0] wr_data_i = '0;
  logic             rsv_en_i = 1'b0;
  logic [AW-1:0]    rsv_adr_i = '0;
  logic [AW:0]      pend_cnt_o, pend_cnt_nb;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_adr_i(rd_adr_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .wr_en_i(wr_en_i), .wr_adr_i(wr_adr_i),
    .wr_data_i(wr_data_i), .rsv_en_i(rsv_en_i), .rsv_adr_i(rsv_adr_i),
    .pend_cnt_o(pend_cnt_o));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
               .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk_i(clk_i), .rst_i(rst_i), .rd_adr_i(rd_adr_i), .rd_data_o(rd_data_nb),
    .rd_busy_o(rd_busy_nb), .wr_en_i(wr_en_i), .wr_adr_i(wr_adr_i),
    .wr_data_i(wr_data_i), .rsv_en_i(rsv_en_i), .rsv_adr_i(rsv_adr_i),
    .pend_cnt_o(pend_cnt_nb));

  always #5 clk_i = ~clk_i;

  // Model: writes applied in port order, then the reservation; r0 untouched.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en_i[j] && wr_adr_i[j*AW +: AW] != 0) begin
          m_mem[wr_adr_i[j*AW +: AW]]  = wr_data_i[j*DW +: DW];
          m_pend[wr_adr_i[j*AW +: AW]] = 1'b0;
        end
      end
      if (rsv_en_i && rsv_adr_i != 0) m_pend[rsv_adr_i] = 1'b1;
    end
  end

  function automatic bit fwd_hit(input logic [AW-1:0] a);
    fwd_hit = 1'b0;
    for (int j = 0; j < NW; j++)
      if (wr_en_i[j] && wr_adr_i[j*AW +: AW] == a) fwd_hit = 1'b1;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    exp_data = m_mem[a];
    if (byp)
      for (int j = 0; j < NW; j++)
        if (wr_en_i[j] && wr_adr_i[j*AW +: AW] == a) exp_data = wr_data_i[j*DW +: DW];
    if (a == 0 || rst_i) exp_data = '0;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    exp_busy = m_pend[a] && !(byp && fwd_hit(a)) && !rst_i && a != 0;
  endfunction

  function automatic int exp_cnt();
    exp_cnt = 0;
    for (int i = 0; i < DEPTH; i++) exp_cnt += int'(m_pend[i]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_on) begin
      for (int k = 0; k < NR; k++) begin
        chk("model rd_data", 64'(rd_data_o[k*DW +: DW]), 64'(exp_data(rd_adr_i[k*AW +: AW], 1'b1)));
        chk("model rd_busy", 64'(rd_busy_o[k]), 64'(exp_busy(rd_adr_i[k*AW +: AW], 1'b1)));
        chk("model nb rd_data", 64'(rd_data_nb[k*DW +: DW]), 64'(exp_data(rd_adr_i[k*AW +: AW], 1'b0)));
        chk("model nb rd_busy", 64'(rd_busy_nb[k]), 64'(exp_busy(rd_adr_i[k*AW +: AW], 1'b0)));
      end
      chk("model pend_cnt", 64'(pend_cnt_o), 64'(exp_cnt()));
      chk("model nb pend_cnt", 64'(pend_cnt_nb), 64'(exp_cnt()));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i  = '0;
    rsv_en_i = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_adr_i[k*AW +: AW] = a;
  endtask

  task automatic wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_i[j]            = 1'b1;
    wr_adr_i[j*AW +: AW]  = a;
    wr_data_i[j*DW +: DW] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en_i  = 1'b1;
    rsv_adr_i = a;
  endtask

  initial begin
    #1 rst_i = 1'b1;
    cmp_on = 1'b1;
    #1;
    chk("reset pend_cnt", 64'(pend_cnt_o), 64'd0);
    chk("reset rd_data", 64'(rd_data_o), 64'd0);
    step();
    step();
    rst_i = 1'b0;

    // 1: every address reads zero, then a single write lands one edge later
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(DEPTH - 1 - a));
      #1;
      chk("init rd0", 64'(rd_data_o[0 +: DW]), 64'd0);
      chk("init rd1", 64'(rd_data_o[DW +: DW]), 64'd0);
      step();
    end
    wr(0, 5'd5, 32'h0000_0005);
    step();
    idle();
    set_rd(0, 5'd5);
    #1 chk("r5 write", 64'(rd_data_o[0 +: DW]), 64'h5);
    step();

    // 2: same-address conflict and zero register
    wr(0, 5'd7, 32'hAAAA_AAAA);
    wr(1, 5'd7, 32'h5555_5555);
    step();
    idle();
    set_rd(0, 5'd7);
    #1 chk("r7 conflict", 64'(rd_data_o[0 +: DW]), 64'h5555_5555);
    wr(0, 5'd0, 32'hFFFF_FFFF);
    set_rd(1, 5'd0);
    #1 chk("r0 no bypass", 64'(rd_data_o[DW +: DW]), 64'd0);
    step();
    idle();
    #1 chk("r0 write dropped", 64'(rd_data_o[DW +: DW]), 64'd0);
    step();

    // 3: bypass vs no bypass
    wr(0, 5'd3, 32'h11);
    step();
    idle();
    wr(0, 5'd3, 32'h22);
    set_rd(0, 5'd3);
    #1;
    chk("bypass new", 64'(rd_data_o[0 +: DW]), 64'h22);
    chk("nobypass old", 64'(rd_data_nb[0 +: DW]), 64'h11);
    step();
    idle();
    #1 chk("nobypass after edge", 64'(rd_data_nb[0 +: DW]), 64'h22);
    step();

    // 4: scoreboard
    rsv(5'd9);
    step();
    idle();
    set_rd(1, 5'd9);
    #1;
    chk("r9 busy", 64'(rd_busy_o[1]), 64'd1);
    chk("r9 cnt", 64'(pend_cnt_o), 64'd1);
    wr(0, 5'd9, 32'h99);
    #1;
    chk("r9 busy bypassed", 64'(rd_busy_o[1]), 64'd0);
    chk("r9 busy nb", 64'(rd_busy_nb[1]), 64'd1);
    step();
    idle();
    #1;
    chk("r9 cleared busy", 64'(rd_busy_o[1]), 64'd0);
    chk("r9 cleared cnt", 64'(pend_cnt_o), 64'd0);
    chk("r9 data", 64'(rd_data_o[DW +: DW]), 64'h99);
    rsv(5'd9);
    wr(1, 5'd9, 32'h123);
    step();
    idle();
    #1;
    chk("rsv wins busy", 64'(rd_busy_o[1]), 64'd1);
    chk("rsv wins cnt", 64'(pend_cnt_o), 64'd1);
    wr(0, 5'd9, 32'h9);
    step();
    idle();
    #1 chk("r9 released", 64'(pend_cnt_o), 64'd0);

    // 5: saturation and zero-register reservation
    for (int a = 1; a < DEPTH; a++) begin
      rsv(AW'(a));
      step();
    end
    idle();
    #1 chk("cnt 31", 64'(pend_cnt_o), 64'd31);
    rsv(5'd0);
    step();
    idle();
    #1 chk("cnt r0 rsv", 64'(pend_cnt_o), 64'd31);
    wr(0, 5'd1, 32'h1);
    wr(1, 5'd2, 32'h2);
    step();
    idle();
    #1 chk("cnt 29", 64'(pend_cnt_o), 64'd29);
    step();

    // 6: asynchronous reset between edges with a write in flight
    set_rd(0, 5'd4);
    set_rd(1, 5'd4);
    wr(0, 5'd4, 32'h44);
    #2 rst_i = 1'b1;
    #1;
    chk("async rst data", 64'(rd_data_o[0 +: DW]), 64'd0);
    chk("async rst busy", 64'(rd_busy_o), 64'd0);
    chk("async rst cnt", 64'(pend_cnt_o), 64'd0);
    idle();
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk("post rst r4", 64'(rd_data_o[0 +: DW]), 64'd0);
    chk("post rst cnt", 64'(pend_cnt_o), 64'd0);
    step();
    step();

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
